sid_voice_scaler: RTL and testbench
===================================

SID_VOICE_SCALER -- requirements
Module: sid_voice_scaler

Interface
REQ-001 SHALL have parameter DC_OFFSET, default 0, signed 12-bit per-voice offset applied only when SID_VOICE_DCOFFSET_EN is defined.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ce_sample  input  1  one-cycle sample tick that starts a scaling pass.
REQ-005 SHALL have ports wave1, wave2, wave3  input  12 each  unsigned oscillator outputs, midscale 2048.
REQ-006 SHALL have ports env1, env2, env3  input  8 each  unsigned envelope levels.
REQ-007 SHALL have ports voice1, voice2, voice3  output  12 each  signed two's-complement scaled voices, the filter stage inputs.
REQ-008 SHALL have port input_valid  output  1  one-cycle strobe: voice1..3 hold a new coherent set.
REQ-009 SHALL have port overrun  output  1  sticky flag: a ce_sample arrived while a pass was in progress.

Function
REQ-010 SHALL implement states IDLE, MUL1, MUL2, MUL3, COMMIT.
REQ-011 IDLE with ce_sample=1 SHALL latch wave1..3 and env1..3 into internal registers and go to MUL1; without ce_sample it SHALL stay in IDLE.
REQ-012 MUL1, MUL2 and MUL3 SHALL each compute one voice, in the order voice 1, 2, 3, using a single shared 13x9 signed multiplier.
REQ-013 Each MULn SHALL advance unconditionally to the next state; MUL3 SHALL go to COMMIT, and COMMIT SHALL go to IDLE.
REQ-014 Per-voice arithmetic SHALL be d = wave - 2048 (13-bit signed), p = d * env (21-bit signed), v = p >>> 8 (arithmetic shift, floor), v SHALL be truncated to 12 bits, and the resulting range -2040..2039 SHALL never overflow.
REQ-015 Results SHALL be written to shadow registers; voice1..3 SHALL update simultaneously in COMMIT, with input_valid=1 in that same cycle only.
REQ-016 If ce_sample is asserted on cycle N while in IDLE, input_valid SHALL be high on cycle N+4 and voice1..3 SHALL show the new values from N+4.
REQ-017 voice1..3 SHALL hold their values between commits.
REQ-018 Input changes after the latch cycle SHALL NOT affect the current pass.
REQ-019 ce_sample in MUL1..COMMIT SHALL be ignored, SHALL NOT restart or extend the pass, and SHALL set overrun.
REQ-020 ce_sample in the cycle the FSM returns from COMMIT to IDLE SHALL be ignored and SHALL set overrun.
REQ-021 overrun SHALL remain set until reset.

Reset
REQ-022 rst SHALL force state=IDLE, voice1..3=0, shadow registers=0, input_valid=0 and overrun=0 on the next clk edge.
REQ-023 rst asserted mid-pass SHALL abort the pass with no input_valid pulse and no partial update of voice1..3.
REQ-024 The first ce_sample after rst deasserts SHALL be serviced normally.

Configuration
REQ-025 With SID_VOICE_DCOFFSET_EN defined, COMMIT SHALL output sat12(v + DC_OFFSET), where sat12 saturates to -2048..2047 per voice.
REQ-026 Without SID_VOICE_DCOFFSET_EN, the output SHALL be v exactly, DC_OFFSET SHALL be unused, and no adder or saturation logic SHALL be present.
REQ-027 Latency SHALL be identical with and without SID_VOICE_DCOFFSET_EN.

Structure
REQ-028 Package sid_pkg SHALL hold the state enum type, the constants WAVE_MID=2048, ENV_SHIFT=8 and VOICE_MIN/VOICE_MAX, and the 12-bit voice sample typedef.
REQ-029 One sub-module, sid_voice_mul, SHALL contain the combinational offset-remove, multiply and shift (inputs wave, env; output v).
REQ-030 The FSM, operand multiplexing, shadow registers and the optional offset/saturation SHALL reside in sid_voice_scaler.

Verification
REQ-031 wave1=4095, env1=255, others 2048/0, ce_sample once -> input_valid 4 cycles later, voice1=2039, voice2=voice3=0.
REQ-032 wave2=0, env2=255; wave3=2047, env3=1 -> voice2=-2040, voice3=-1 (floor); wave1=3072, env1=128 -> voice1=512.
REQ-033 Pulse ce_sample at cycles 0, 2 and 4 -> exactly one input_valid (cycle 4), the cycle-4 tick ignored, overrun=1; a tick at cycle 5 -> input_valid at cycle 9.
REQ-034 Change wave1 from 4095 to 0 at cycle 1 after the ce_sample -> committed voice1=2039.
REQ-035 Assert rst at cycle 2 of a pass -> no input_valid, voice outputs 0, overrun 0, state IDLE.
REQ-036 Build with SID_VOICE_DCOFFSET_EN and DC_OFFSET=100; wave=4095, env=255 -> voice=2047 (saturated); wave=2048 -> voice=100.

Source files
------------

// File: rtl/sid_pkg.sv
// sid_pkg: shared state type, voice sample type and scaling constants for the SID voice path.
package sid_pkg;
    typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, COMMIT} state_t;
    typedef logic signed [11:0] voice_t;
    localparam int WAVE_MID  = 2048;
    localparam int ENV_SHIFT = 8;
    localparam int VOICE_MIN = -2048;
    localparam int VOICE_MAX = 2047;
    function automatic voice_t sat12(input logic signed [12:0] x);
        return (x > 13'(VOICE_MAX)) ? voice_t'(VOICE_MAX) :
               (x < 13'(VOICE_MIN)) ? voice_t'(VOICE_MIN) : x[11:0];
    endfunction
endpackage

// File: rtl/sid_voice_mul.sv
// sid_voice_mul: removes the oscillator midscale, multiplies by the envelope and scales back to 12 bits.
module sid_voice_mul
    import sid_pkg::*;
(
    input  logic [11:0] wave,
    input  logic [7:0]  env,
    output voice_t      v
);
    logic signed [12:0] d;
    logic signed [20:0] p;
    always_comb begin
        d = $signed({1'b0, wave}) - 13'(WAVE_MID);
        p = 21'(d) * 21'($signed({1'b0, env}));
        // |p| < 2^20, so the shifted result always fits the 12-bit range
        v = 12'(p >>> ENV_SHIFT);
    end
endmodule

// File: rtl/sid_voice_scaler.sv
// sid_voice_scaler: time-shares one multiplier over three voices and commits them together.
// Optional feature: define SID_VOICE_DCOFFSET_EN to add a saturated DC_OFFSET to every voice.
module sid_voice_scaler
    import sid_pkg::*;
#(
    parameter int DC_OFFSET = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_sample,
    input  logic [11:0] wave1,
    input  logic [11:0] wave2,
    input  logic [11:0] wave3,
    input  logic [7:0]  env1,
    input  logic [7:0]  env2,
    input  logic [7:0]  env3,
    output voice_t      voice1,
    output voice_t      voice2,
    output voice_t      voice3,
    output logic        input_valid,
    output logic        overrun
);
    state_t      state;
    logic [11:0] w1, w2, w3;
    logic [7:0]  e1, e2, e3;
    voice_t      sh1, sh2;
    logic [11:0] wave_sel;
    logic [7:0]  env_sel;
    voice_t      v;

    if (DC_OFFSET < VOICE_MIN || DC_OFFSET > VOICE_MAX) begin : g_bad_offset
        $error("DC_OFFSET must fit in 12 signed bits");
    end

    function automatic voice_t commit_f(input voice_t x);
`ifdef SID_VOICE_DCOFFSET_EN
        return sat12(13'(x) + 13'(DC_OFFSET));
`else
        return x;
`endif
    endfunction

    always_comb begin
        wave_sel = (state == MUL1) ? w1 : (state == MUL2) ? w2 : w3;
        env_sel  = (state == MUL1) ? e1 : (state == MUL2) ? e2 : e3;
    end

    sid_voice_mul u_mul (.wave(wave_sel), .env(env_sel), .v(v));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            {w1, w2, w3} <= '0;
            {e1, e2, e3} <= '0;
            sh1         <= '0;
            sh2         <= '0;
            voice1      <= '0;
            voice2      <= '0;
            voice3      <= '0;
            input_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            input_valid <= 1'b0;
            if (ce_sample && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (ce_sample) begin
                    {w1, w2, w3} <= {wave1, wave2, wave3};
                    {e1, e2, e3} <= {env1, env2, env3};
                    state        <= MUL1;
                end
                MUL1: begin
                    sh1   <= v;
                    state <= MUL2;
                end
                MUL2: begin
                    sh2   <= v;
                    state <= MUL3;
                end
                // voice 3 goes straight out so all three appear together in COMMIT
                MUL3: begin
                    voice1      <= commit_f(sh1);
                    voice2      <= commit_f(sh2);
                    voice3      <= commit_f(v);
                    input_valid <= 1'b1;
                    state       <= COMMIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sid_voice_scaler.sv
// tb_sid_voice_scaler: directed scoreboard bench for sid_voice_scaler (honours SID_VOICE_DCOFFSET_EN).
module tb_sid_voice_scaler;
`ifdef SID_VOICE_DCOFFSET_EN
    localparam int OFS = 100;
`else
    localparam int OFS = 0;
`endif
    typedef struct {int due; int v1; int v2; int v3;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce_sample = 1'b0;
    logic [11:0] wave1 = 12'd2048, wave2 = 12'd2048, wave3 = 12'd2048;
    logic [7:0] env1 = '0, env2 = '0, env3 = '0;
    logic signed [11:0] voice1, voice2, voice3;
    logic input_valid, overrun;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    exp_t q[$];

    sid_voice_scaler #(.DC_OFFSET(OFS)) dut (
        .clk(clk), .rst(rst), .ce_sample(ce_sample),
        .wave1(wave1), .wave2(wave2), .wave3(wave3),
        .env1(env1), .env2(env2), .env3(env3),
        .voice1(voice1), .voice2(voice2), .voice3(voice3),
        .input_valid(input_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ofs(input int v);
        int s;
`ifdef SID_VOICE_DCOFFSET_EN
        s = v + OFS;
        s = (s > 2047) ? 2047 : (s < -2048) ? -2048 : s;
`else
        s = v;
`endif
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every input_valid pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (input_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("valid_cycle", cyc, e.due);
                chk("voice1", int'(voice1), e.v1);
                chk("voice2", int'(voice2), e.v2);
                chk("voice3", int'(voice3), e.v3);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ce_sample = 1'b0;
        end
    endtask

    task automatic pulse(input int a1, input int a2, input int a3,
                         input int b1, input int b2, input int b3,
                         input bit acc, input int x1, input int x2, input int x3);
        @(posedge clk); #1;
        wave1 = 12'(a1); wave2 = 12'(a2); wave3 = 12'(a3);
        env1 = 8'(b1); env2 = 8'(b2); env3 = 8'(b3);
        ce_sample = 1'b1;
        if (acc) q.push_back('{cyc + 4, ofs(x1), ofs(x2), ofs(x3)});
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_voice1", int'(voice1), 0);
        chk("reset_voice2", int'(voice2), 0);
        chk("reset_voice3", int'(voice3), 0);
        chk("reset_valid", int'(input_valid), 0);
        chk("reset_overrun", int'(overrun), 0);

        pulse(4095, 2048, 2048, 255, 0, 0, 1, 2039, 0, 0);
        idle(7);
        pulse(3072, 0, 2047, 128, 255, 1, 1, 512, -2040, -1);
        idle(7);
        // wave1 changes right after the latch cycle and must not leak in
        pulse(4095, 2560, 1536, 255, 200, 100, 1, 2039, 400, -200);
        @(posedge clk); #1;
        ce_sample = 1'b0;
        wave1 = 12'd0;
        idle(7);
        chk("hold_voice1", int'(voice1), ofs(2039));
        chk("no_overrun_yet", int'(overrun), 0);

        pulse(3000, 1000, 2048, 10, 50, 255, 1, 37, -205, 0);
        idle(1);
        pulse(4095, 4095, 4095, 255, 255, 255, 0, 0, 0, 0);
        idle(1);
        pulse(4095, 4095, 4095, 255, 255, 255, 0, 0, 0, 0);
        pulse(1024, 2049, 4095, 64, 255, 16, 1, -256, 0, 127);
        idle(8);
        chk("overrun_set", int'(overrun), 1);

        pulse(0, 0, 0, 255, 255, 255, 0, 0, 0, 0);
        idle(1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);
        @(negedge clk);
        chk("abort_voice1", int'(voice1), 0);
        chk("abort_voice2", int'(voice2), 0);
        chk("abort_voice3", int'(voice3), 0);
        chk("abort_overrun", int'(overrun), 0);

        pulse(2047, 0, 3072, 255, 1, 255, 1, -1, -8, 1020);
        idle(8);
        chk("final_hold_voice1", int'(voice1), ofs(-1));
        chk("final_overrun", int'(overrun), 0);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
